// File: rtl/bus_sync_pkg.sv
// Shared definitions for the bus_sync_rx receiver slice.
//   state_t          : receiver FSM encoding (IDLE / SETTLE / HOLD)
//   CNT_W            : width of the settle-window down-counter
//   *_MIN / *_MAX    : legal ranges of the receiver parameters
//   settle_load()    : counter preload for a given settle window length
package bus_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;
    localparam int SETTLE_CYCLES_MIN = 1;
    localparam int SETTLE_CYCLES_MAX = 15;

    // The counter is loaded on the IDLE->SETTLE edge and the capture happens
    // on the cycle it reads zero, so a window of N cycles preloads N-1.
    function automatic logic [CNT_W-1:0] settle_load(input int settle_cycles);
        return CNT_W'(settle_cycles - 1);
    endfunction

endpackage

// File: rtl/bus_sync_rx_sync_chain.sv
// N-flop synchronizer for the request toggle.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
// The stage register carries the same attributes as the bus false-path flop
// so the tools neither duplicate it, fold it into a shift-register primitive,
// nor optimise it away. The instance name (u_req_sync in the top) is what the
// timing constraint on req_tog_in refers to.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* async_reg = "true", shreg_extract = "no", dont_touch = "true", keep = "true" *)
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/bus_sync_rx.sv
// Destination-domain receiver for a toggle-request / toggle-acknowledge bus
// crossing. The sender holds data_in stable and flips req_tog_in once per
// word; this block synchronizes the toggle, waits a settle window, captures
// data_in and offers it on a valid/ready port, then flips ack_tog_out.
//   clk, rst      : destination clock, synchronous active-high reset
//   req_tog_in    : asynchronous request toggle from the sender
//   data_in       : bus from the false-path flop, sampled after settling
//   data_out      : captured word, stable while out_valid is high
//   out_valid     : data_out holds an unconsumed word
//   out_ready     : consumer accepts the word (ignored while out_valid=0)
//   ack_tog_out   : acknowledge toggle back to the sender
//   busy          : FSM is not in IDLE (registered)
//   protocol_err  : sticky, a request edge arrived while not IDLE
//
// Handshake: a word transfers on any rising clk edge where out_valid and
// out_ready are both high. out_valid is a pure register output and never
// depends combinationally on out_ready; once raised it stays high, with
// data_out frozen, until that transfer edge.
//
// Legal parameter ranges: SYNC_STAGES 2..4, SETTLE_CYCLES 1..15 (see package).
module bus_sync_rx
    import bus_sync_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_tog_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ack_tog_out,
    output logic             busy,
    output logic             protocol_err
);

    logic             req_s;
    logic             req_prev;
    logic             req_edge;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tog_in),
        .q   (req_s)
    );

    // Any change of the synchronized toggle is one request.
    assign req_edge = req_s ^ req_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev     <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            data_out     <= '0;
            out_valid    <= 1'b0;
            ack_tog_out  <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            // req_prev follows req_s unconditionally, so an edge dropped as a
            // protocol error is consumed here and never reappears later.
            req_prev <= req_s;

            case (state)
                IDLE: begin
                    if (req_edge) begin
                        state <= SETTLE;
                        cnt   <= settle_load(SETTLE_CYCLES);
                        busy  <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (req_edge) begin
                        protocol_err <= 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        data_out  <= data_in;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    // An edge coincident with the handshake is still an
                    // error: the sender could not have seen this ack yet.
                    if (req_edge) begin
                        protocol_err <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        ack_tog_out <= ~ack_tog_out;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sync_rx.sv
// Self-checking bench for bus_sync_rx. The main instance uses the default
// parameters; two extra instances (SYNC_STAGES=3, SETTLE_CYCLES=1 and 15)
// share one stimulus for the latency sweep. Expected values come from a
// behavioural model: a queue of words sent, the ack parity implied by the
// number of completed handshakes, and the latency formula.
module tb_bus_sync_rx;

    localparam int W = 32;

    // Expected latency counted in clk edges, the sampling edge being edge 1.
    localparam int LAT0  = 2 + 2 + 1;
    localparam int LAT_A = 3 + 1 + 1;
    localparam int LAT_B = 3 + 15 + 1;

    logic         clk;
    logic         rst;

    logic         req0, ready0;
    logic [W-1:0] data0, dout0;
    logic         valid0, ack0, busy0, perr0;

    logic         req1, ready1;
    logic [W-1:0] data1, dout_a, dout_b;
    logic         valid_a, ack_a, busy_a, perr_a;
    logic         valid_b, ack_b, busy_b, perr_b;

    int total;
    int bad;

    logic [W-1:0] exp_q[$];
    logic         ack_model;

    bus_sync_rx #(.WIDTH(W), .SYNC_STAGES(2), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_tog_in(req0), .data_in(data0),
        .data_out(dout0), .out_valid(valid0), .out_ready(ready0),
        .ack_tog_out(ack0), .busy(busy0), .protocol_err(perr0)
    );

    bus_sync_rx #(.WIDTH(W), .SYNC_STAGES(3), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req_tog_in(req1), .data_in(data1),
        .data_out(dout_a), .out_valid(valid_a), .out_ready(ready1),
        .ack_tog_out(ack_a), .busy(busy_a), .protocol_err(perr_a)
    );

    bus_sync_rx #(.WIDTH(W), .SYNC_STAGES(3), .SETTLE_CYCLES(15)) dut_b (
        .clk(clk), .rst(rst), .req_tog_in(req1), .data_in(data1),
        .data_out(dout_b), .out_valid(valid_b), .out_ready(ready1),
        .ack_tog_out(ack_b), .busy(busy_b), .protocol_err(perr_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete word through the main instance. hold_cycles > 0 keeps
    // out_ready low that long after out_valid rises; zero_bus drops data_in
    // to 0 during the hold to prove the captured word does not follow it.
    task automatic xfer0(input logic [W-1:0] w, input int hold_cycles, input bit zero_bus);
        int           n;
        bit           seen;
        logic [W-1:0] exp_w;
        data0  = w;
        ready0 = (hold_cycles == 0);
        req0   = ~req0;
        exp_q.push_back(w);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (valid0) seen = 1;
        end
        check("latency", seen ? W'(n) : W'(0), W'(LAT0));
        exp_w = exp_q.pop_front();
        check("data", dout0, exp_w);
        if (hold_cycles > 0) begin
            if (zero_bus) data0 = '0;
            for (int i = 0; i < hold_cycles; i++) begin
                step();
                check("hold_valid", W'(valid0), W'(1));
                check("hold_data", dout0, exp_w);
                check("hold_ack", W'(ack0), W'(ack_model));
            end
            ready0 = 1'b1;
        end
        step();
        ack_model = ~ack_model;
        check("valid_drop", W'(valid0), W'(0));
        check("ack_flip", W'(ack0), W'(ack_model));
        check("idle_busy", W'(busy0), W'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int           n;
        bit           seen;
        int           lat_a, lat_b;
        logic [W-1:0] cap_a, cap_b, w;

        total     = 0;
        bad       = 0;
        ack_model = 1'b0;
        rst    = 1'b1;
        req0   = 1'b0;
        ready0 = 1'b1;
        data0  = '0;
        req1   = 1'b0;
        ready1 = 1'b1;
        data1  = '0;

        // reset state
        step();
        step();
        rst = 1'b0;
        check("rst_dout", dout0, '0);
        check("rst_valid", W'(valid0), W'(0));
        check("rst_ack", W'(ack0), W'(0));
        check("rst_busy", W'(busy0), W'(0));
        check("rst_perr", W'(perr0), W'(0));
        step();
        check("idle_no_edge", W'(busy0), W'(0));

        // basic transfer
        xfer0(32'hDEADBEEF, 0, 0);

        // backpressure with bus changing under the held word
        xfer0(32'hDEADBEEF, 10, 1);

        // back-to-back words, ack parity 1,0,1,0
        for (int i = 1; i <= 4; i++) begin
            xfer0(W'(i), 0, 0);
        end
        check("b2b_perr", W'(perr0), W'(0));

        // random words and random backpressure
        for (int i = 0; i < 8; i++) begin
            xfer0($urandom, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
        end
        check("rand_perr", W'(perr0), W'(0));

        // protocol violation: second toggle while the first is in flight
        w      = 32'hA5A50001;
        data0  = w;
        ready0 = 1'b0;
        req0   = ~req0;
        n      = 0;
        while (!busy0 && n < 20) begin
            step();
            n++;
        end
        check("viol_busy", W'(busy0), W'(1));
        req0 = ~req0;
        repeat (8) step();
        check("viol_perr", W'(perr0), W'(1));
        check("viol_valid", W'(valid0), W'(1));
        check("viol_data", dout0, w);
        ready0 = 1'b1;
        step();
        ack_model = ~ack_model;
        check("viol_ack", W'(ack0), W'(ack_model));
        for (int i = 0; i < 8; i++) begin
            step();
            check("viol_no_phantom", W'(valid0 | busy0), W'(0));
        end
        check("viol_sticky", W'(perr0), W'(1));
        xfer0($urandom, 2, 0);
        check("viol_sticky_after", W'(perr0), W'(1));

        // reset while holding a word
        data0  = 32'h0BADF00D;
        ready0 = 1'b0;
        req0   = ~req0;
        n      = 0;
        seen   = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (valid0) seen = 1;
        end
        check("mid_valid", W'(valid0), W'(1));
        rst  = 1'b1;
        req0 = 1'b0;
        step();
        rst       = 1'b0;
        ack_model = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", W'(valid0), W'(0));
        check("mid_rst_ack", W'(ack0), W'(0));
        check("mid_rst_busy", W'(busy0), W'(0));
        check("mid_rst_dout", dout0, '0);
        check("mid_rst_perr", W'(perr0), W'(0));
        ready0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_no_ack", W'(ack0 | valid0 | busy0), W'(0));
        end
        xfer0(32'h12345678, 0, 0);

        // parameter sweep on the two extra instances
        for (int k = 0; k < 2; k++) begin
            w     = $urandom;
            data1 = w;
            req1  = ~req1;
            lat_a = 0;
            lat_b = 0;
            cap_a = '0;
            cap_b = '0;
            for (int e = 1; e <= 30; e++) begin
                step();
                if (valid_a && lat_a == 0) begin lat_a = e; cap_a = dout_a; end
                if (valid_b && lat_b == 0) begin lat_b = e; cap_b = dout_b; end
            end
            check("sweep_lat_s1", W'(lat_a), W'(LAT_A));
            check("sweep_lat_s15", W'(lat_b), W'(LAT_B));
            check("sweep_data_s1", cap_a, w);
            check("sweep_data_s15", cap_b, w);
            check("sweep_ack_s1", W'(ack_a), W'(k == 0));
            check("sweep_ack_s15", W'(ack_b), W'(k == 0));
            check("sweep_idle", W'(valid_a | valid_b | busy_a | busy_b | perr_a | perr_b), W'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
